// File: rtl/tc_rst_seq_if.sv
// Signal bundle between the reset sequencer and its surroundings: lock and
// software request in, staged resets and status out.
interface tc_rst_seq_if #(
    parameter int NSTAGE = 4
);
    logic              locked_i;
    logic              sw_req;
    logic              sw_ack;
    logic [NSTAGE-1:0] rst_o_n;
    logic              done;
    logic [7:0]        fault_cnt;

    modport master (
        output locked_i,
        output sw_req,
        input  sw_ack,
        input  rst_o_n,
        input  done,
        input  fault_cnt
    );

    modport slave (
        input  locked_i,
        input  sw_req,
        output sw_ack,
        output rst_o_n,
        output done,
        output fault_cnt
    );
endinterface

// File: rtl/tc_rst_seq.sv
// Reset release sequencer for the 125 MHz domain: waits for PLL lock, holds,
// then releases the stage resets one at a time; supports software re-sequence.
module tc_rst_seq #(
    parameter int NSTAGE    = 4,
    parameter int HOLD_CYC  = 64,
    parameter int STAGE_DLY = 256
) (
    input  logic           clki,
    input  logic           rsti_n,
    tc_rst_seq_if.slave    bus
);

    localparam int MAXC = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NSTAGE + 1);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]     DLY_LAST  = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0]     CNT_ZERO  = {CW{1'b0}};
    localparam logic [IW-1:0]     IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]     IDX_LAST  = IW'(NSTAGE - 1);
    localparam logic [NSTAGE-1:0] RST_ALL   = {NSTAGE{1'b0}};

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              lock_meta_r;
    logic              lock_sync_r;
    logic [1:0]        state_r,  state_s;
    logic [CW-1:0]     cnt_r,    cnt_s;
    logic [IW-1:0]     idx_r,    idx_s;
    logic [NSTAGE-1:0] rst_n_r,  rst_n_s;
    logic              done_r,   done_s;
    logic              ack_r,    ack_s;
    logic              pend_r,   pend_s;
    logic [7:0]        fault_r,  fault_s;
    logic [NSTAGE-1:0] stage_mask_s;
    logic              lose_s;

    // Two-flop synchronizer bringing the PLL lock into the clki domain
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= bus.locked_i;
            lock_sync_r <= lock_meta_r;
        end
    end

    // One-hot mask of the stage currently being released
    always_comb begin
        stage_mask_s = RST_ALL;
        for (int k = 0; k < NSTAGE; k++) begin
            stage_mask_s[k] = (idx_r == IW'(k));
        end
    end

    // Next-state logic; a lock loss outside WAIT_LOCK overrides everything else
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rst_n_s = rst_n_r;
        done_s  = done_r;
        ack_s   = 1'b0;
        pend_s  = pend_r;
        fault_s = fault_r;
        lose_s  = (state_r != ST_WAIT_LOCK) && !lock_sync_r;

        if (lose_s) begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = CNT_ZERO;
            idx_s   = IDX_ZERO;
            rst_n_s = RST_ALL;
            done_s  = 1'b0;
            pend_s  = 1'b0;
            fault_s = sat_inc8(fault_r);
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    cnt_s   = CNT_ZERO;
                    rst_n_s = RST_ALL;
                    done_s  = 1'b0;
                    pend_s  = 1'b0;
                    if (lock_sync_r) begin
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_s = ST_RELEASE;
                        cnt_s   = CNT_ZERO;
                        idx_s   = IDX_ZERO;
                    end else begin
                        cnt_s   = cnt_r + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_r == DLY_LAST) begin
                        cnt_s   = CNT_ZERO;
                        rst_n_s = rst_n_r | stage_mask_s;
                        idx_s   = idx_r + IW'(1);
                        if (idx_r == IDX_LAST) begin
                            state_s = ST_RUN;
                            done_s  = 1'b1;
                            ack_s   = pend_r;
                            pend_s  = 1'b0;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s   = cnt_r + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.sw_req) begin
                        state_s = ST_HOLD;
                        cnt_s   = CNT_ZERO;
                        rst_n_s = RST_ALL;
                        done_s  = 1'b0;
                        pend_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_WAIT_LOCK;
                    cnt_s   = CNT_ZERO;
                    idx_s   = IDX_ZERO;
                    rst_n_s = RST_ALL;
                    done_s  = 1'b0;
                    pend_s  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            rst_n_r <= RST_ALL;
            done_r  <= 1'b0;
            ack_r   <= 1'b0;
            pend_r  <= 1'b0;
            fault_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            rst_n_r <= rst_n_s;
            done_r  <= done_s;
            ack_r   <= ack_s;
            pend_r  <= pend_s;
            fault_r <= fault_s;
        end
    end

    assign bus.rst_o_n   = rst_n_r;
    assign bus.done      = done_r;
    assign bus.sw_ack    = ack_r;
    assign bus.fault_cnt = fault_r;

endmodule

// File: tb/tb_tc_rst_seq.sv
// Self-checking bench for tc_rst_seq: vector table, directed corner cases and
// a random soak against a timeline-based reference model.
module tb_tc_rst_seq;

    localparam int N = 4;
    localparam int H = 4;
    localparam int S = 8;
    localparam int T = H + N * S;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    tc_rst_seq_if #(.NSTAGE(N)) bus ();

    tc_rst_seq #(.NSTAGE(N), .HOLD_CYC(H), .STAGE_DLY(S)) dut (
        .clki   (clk),
        .rsti_n (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a sequence is "active" from the edge HOLD starts;
    // everything else follows from elapsed edges since that start.
    int m_n, m_t0, m_fault;
    bit m_active, m_sw, m_s1, m_s2;

    task automatic model_reset();
        m_n = 0; m_t0 = 0; m_fault = 0;
        m_active = 1'b0; m_sw = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic model_edge();
        bit l;
        m_n++;
        l    = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.locked_i;
        if (!m_active) begin
            if (l) begin m_active = 1'b1; m_t0 = m_n; m_sw = 1'b0; end
        end else if (!l) begin
            m_active = 1'b0;
            m_fault  = (m_fault < 255) ? m_fault + 1 : 255;
        end else if (bus.sw_req && (m_n - 1 - m_t0) >= T) begin
            m_t0 = m_n; m_sw = 1'b1;
        end
    endtask

    function automatic logic [13:0] model_out();
        logic [3:0] r;
        logic d, a;
        int e;
        r = 4'b0000; d = 1'b0; a = 1'b0;
        e = m_n - m_t0;
        if (m_active) begin
            for (int k = 0; k < N; k++) r[k] = (e >= H + (k + 1) * S);
            d = (e >= T);
            a = m_sw && (e == T);
        end
        return {r, d, a, 8'(m_fault)};
    endfunction

    function automatic logic [13:0] dut_out();
        return {bus.rst_o_n, bus.done, bus.sw_ack, bus.fault_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("model", 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.locked_i = 1'b0;
        bus.sw_req = 1'b0;
        model_reset();
        repeat (5) tick();
    endtask

    typedef struct {
        logic       locked;
        logic       sw_req;
        int         cycles;
        logic [3:0] rst;
        logic       done;
        logic       ack;
        logic [7:0] fault;
    } vec_t;

    vec_t tbl[16];
    bit   ack_seen;
    int   hi, lo;

    initial begin
        n_vec = 0; n_bad = 0;
        tbl[0]  = '{1'b1, 1'b0, 14, 4'b0000, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0,  1, 4'b0001, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0,  7, 4'b0001, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0,  1, 4'b0011, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0,  8, 4'b0111, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0,  7, 4'b0111, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0,  1, 4'b1111, 1'b1, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0,  5, 4'b1111, 1'b1, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b1,  1, 4'b0000, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 11, 4'b0000, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0,  1, 4'b0001, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b0,  8, 4'b0011, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 1'b0,  8, 4'b0111, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b1, 1'b0,  7, 4'b0111, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 1'b0,  1, 4'b1111, 1'b1, 1'b1, 8'd0};
        tbl[15] = '{1'b1, 1'b0,  1, 4'b1111, 1'b1, 1'b0, 8'd0};

        // Reset state, then power-up and software re-sequence from the table
        do_reset();
        check("reset_outputs", 32'(dut_out()), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.locked_i = tbl[i].locked;
            bus.sw_req   = tbl[i].sw_req;
            repeat (tbl[i].cycles) tick();
            check($sformatf("tbl[%0d]", i), 32'(dut_out()),
                  32'({tbl[i].rst, tbl[i].done, tbl[i].ack, tbl[i].fault}));
        end

        // sw_req held through WAIT_LOCK/HOLD/RELEASE is ignored
        do_reset();
        rst_n = 1'b1; bus.locked_i = 1'b1; bus.sw_req = 1'b1;
        repeat (38) tick();
        check("swhold_e38_rst", 32'(bus.rst_o_n), 32'h7);
        bus.sw_req = 1'b0;
        tick();
        check("swhold_e39", 32'(dut_out()), 32'({4'b1111, 1'b1, 1'b0, 8'd0}));
        ack_seen = 1'b0;
        repeat (4) begin tick(); ack_seen |= bus.sw_ack; end
        check("swhold_no_ack", 32'(ack_seen), 32'd0);

        // Lock loss after stage 0 released, then full power-up timing again
        do_reset();
        rst_n = 1'b1; bus.locked_i = 1'b1;
        repeat (20) tick();
        bus.locked_i = 1'b0;
        repeat (2) tick();
        check("loss_e2_rst", 32'(bus.rst_o_n), 32'h1);
        tick();
        check("loss_e3", 32'({bus.rst_o_n, bus.done, bus.fault_cnt}), 32'({4'b0000, 1'b0, 8'd1}));
        bus.locked_i = 1'b1;
        repeat (14) tick();
        check("relock_e14", 32'(bus.rst_o_n), 32'h0);
        tick();
        check("relock_e15", 32'(bus.rst_o_n), 32'h1);
        repeat (24) tick();
        check("relock_e39", 32'({bus.rst_o_n, bus.done}), 32'({4'b1111, 1'b1}));

        // sw_req on the same edge the lost lock reaches the FSM in RUN
        bus.locked_i = 1'b0;
        repeat (2) tick();
        bus.sw_req = 1'b1;
        tick();
        check("combo_fault", 32'({bus.rst_o_n, bus.done, bus.fault_cnt}), 32'({4'b0000, 1'b0, 8'd2}));
        bus.sw_req = 1'b0; bus.locked_i = 1'b1;
        ack_seen = 1'b0;
        repeat (42) begin tick(); ack_seen |= bus.sw_ack; end
        check("combo_no_ack", 32'({ack_seen, bus.done}), 32'({1'b0, 1'b1}));

        // Asynchronous reset in the middle of a software-initiated RELEASE
        bus.sw_req = 1'b1;
        tick();
        bus.sw_req = 1'b0;
        repeat (20) tick();
        check("pre_areset_rst", 32'(bus.rst_o_n), 32'h3);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_outputs", 32'(dut_out()), 32'd0);
        repeat (3) tick();

        // 300 lock-loss events saturate the fault counter
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            hi = $urandom_range(3, 6);
            lo = $urandom_range(3, 6);
            bus.locked_i = 1'b1;
            repeat (hi) tick();
            bus.locked_i = 1'b0;
            repeat (lo) tick();
        end
        check("fault_sat", 32'(bus.fault_cnt), 32'd255);

        // Random soak against the model
        do_reset();
        rst_n = 1'b1; bus.locked_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) bus.locked_i = ~bus.locked_i;
            bus.sw_req = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
